mips_test_seq: RTL

MIPS_TEST_SEQ -- requirements
Module: mips_test_seq

---
 rtl/mips_seq_pkg.sv | 19 +
 rtl/mips_seq_table.sv | 33 +++
 rtl/mips_test_seq.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mips_seq_pkg.sv
// Shared types and default sizing for the MIPS self-test sequencer.
package mips_seq_pkg;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_ADDR_W      = 10;
  localparam int DEF_PROG_DEPTH  = 16;
  localparam int DEF_CHK_DEPTH   = 4;
  localparam int DEF_TIMEOUT_CYC = 1024;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    CHK_REQ,
    CHK_CMP,
    DONE
  } state_e;

endpackage

// File: rtl/mips_seq_table.sv
// Register array of {address, data} pairs with one write port and one
// combinational read port; used for both the image table and the check table.
module mips_seq_table #(
  parameter int DEPTH = 16,
  parameter int AW    = 10,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] wr_idx_i,
  input  logic [AW-1:0]            wr_addr_i,
  input  logic [DW-1:0]            wr_data_i,
  input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
  output logic [AW-1:0]            rd_addr_o,
  output logic [DW-1:0]            rd_data_o
);

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];

  // NOTE: storage arrays carry no reset, so table contents survive a sequencer
  // reset and map onto plain flops or register-file cells.
  always_ff @(posedge clk) begin
    if (we_i) begin
      addr_q[wr_idx_i] <= wr_addr_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_addr_o = addr_q[rd_idx_i];
  assign rd_data_o = data_q[rd_idx_i];

endmodule

// File: rtl/mips_test_seq.sv
// Self-test sequencer: loads an image into core memory, releases the core until
// it halts, then reads back and compares words. Optional run-phase watchdog is
// enabled with the MIPS_SEQ_TIMEOUT_EN macro.
module mips_test_seq
  import mips_seq_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int PROG_DEPTH  = DEF_PROG_DEPTH,
  parameter int CHK_DEPTH   = DEF_CHK_DEPTH,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          img_we,
  input  logic [$clog2(PROG_DEPTH)-1:0] img_idx,
  input  logic [ADDR_W-1:0]             img_addr,
  input  logic [DATA_W-1:0]             img_data,
  input  logic                          chk_we,
  input  logic [$clog2(CHK_DEPTH)-1:0]  chk_idx,
  input  logic [ADDR_W-1:0]             chk_addr,
  input  logic [DATA_W-1:0]             chk_exp,
  input  logic [$clog2(PROG_DEPTH):0]   img_len,
  input  logic [$clog2(CHK_DEPTH):0]    chk_len,
  input  logic                          start,
  output logic                          core_hold,
  input  logic                          core_halted,
  output logic                          mem_we,
  output logic                          mem_re,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic                          timeout,
  output logic [$clog2(CHK_DEPTH)-1:0]  fail_idx
);

  localparam int PW = $clog2(PROG_DEPTH);
  localparam int CW = $clog2(CHK_DEPTH);
  localparam logic [PW:0] PROG_MAX = PROG_DEPTH[PW:0];
  localparam logic [CW:0] CHK_MAX  = CHK_DEPTH[CW:0];

  state_e         state_q;
  logic [PW-1:0]  img_ptr_q;
  logic [CW-1:0]  chk_ptr_q;
  logic [PW:0]    img_len_q;
  logic [CW:0]    chk_len_q;
  logic           done_q;
  logic           pass_q;
  logic           mismatch_q;
  logic [CW-1:0]  fail_idx_q;

  logic [PW:0]    img_len_d;
  logic [CW:0]    chk_len_d;
  logic           img_last;
  logic           chk_last;
  logic           cmp_miss;
  logic           idle;

  logic [ADDR_W-1:0] img_rd_addr;
  logic [DATA_W-1:0] img_rd_data;
  logic [ADDR_W-1:0] chk_rd_addr;
  logic [DATA_W-1:0] chk_rd_exp;

  assign idle = (state_q == IDLE);

  mips_seq_table #(.DEPTH(PROG_DEPTH), .AW(ADDR_W), .DW(DATA_W)) u_img_tab (
    .clk       (clk),
    .we_i      (img_we && idle),
    .wr_idx_i  (img_idx),
    .wr_addr_i (img_addr),
    .wr_data_i (img_data),
    .rd_idx_i  (img_ptr_q),
    .rd_addr_o (img_rd_addr),
    .rd_data_o (img_rd_data)
  );

  mips_seq_table #(.DEPTH(CHK_DEPTH), .AW(ADDR_W), .DW(DATA_W)) u_chk_tab (
    .clk       (clk),
    .we_i      (chk_we && idle),
    .wr_idx_i  (chk_idx),
    .wr_addr_i (chk_addr),
    .wr_data_i (chk_exp),
    .rd_idx_i  (chk_ptr_q),
    .rd_addr_o (chk_rd_addr),
    .rd_data_o (chk_rd_exp)
  );

  assign img_len_d = (img_len > PROG_MAX) ? PROG_MAX : img_len;
  assign chk_len_d = (chk_len > CHK_MAX)  ? CHK_MAX  : chk_len;
  assign img_last  = ({1'b0, img_ptr_q} == img_len_q - (PW+1)'(1));
  assign chk_last  = ({1'b0, chk_ptr_q} == chk_len_q - (CW+1)'(1));
  assign cmp_miss  = (mem_rdata != chk_rd_exp);

`ifdef MIPS_SEQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] CYC_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] cyc_q;
  logic          timeout_q;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  // NOTE: every register in this block uses <= so all of them update together
  // from the same pre-edge values, whatever order the statements appear in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      img_ptr_q  <= '0;
      chk_ptr_q  <= '0;
      img_len_q  <= '0;
      chk_len_q  <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      mismatch_q <= 1'b0;
      fail_idx_q <= '0;
`ifdef MIPS_SEQ_TIMEOUT_EN
      cyc_q      <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            mismatch_q <= 1'b0;
            fail_idx_q <= '0;
            img_ptr_q  <= '0;
            chk_ptr_q  <= '0;
            img_len_q  <= img_len_d;
            chk_len_q  <= chk_len_d;
`ifdef MIPS_SEQ_TIMEOUT_EN
            cyc_q      <= '0;
            timeout_q  <= 1'b0;
`endif
            state_q    <= (img_len_d == '0) ? RUN : LOAD;
          end
        end
        LOAD: begin
          if (img_last) state_q <= RUN;
          else          img_ptr_q <= img_ptr_q + PW'(1);
        end
        RUN: begin
          // Halt wins over the watchdog when both land on the same cycle.
          if (core_halted) begin
            if (chk_len_q == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
            end else begin
              state_q <= CHK_REQ;
            end
          end
`ifdef MIPS_SEQ_TIMEOUT_EN
          else if (cyc_q == CYC_LAST) begin
            timeout_q <= 1'b1;
            state_q   <= DONE;
            done_q    <= 1'b1;
            pass_q    <= 1'b0;
          end else begin
            cyc_q <= cyc_q + TW'(1);
          end
`endif
        end
        CHK_REQ: state_q <= CHK_CMP;
        CHK_CMP: begin
          if (cmp_miss && !mismatch_q) begin
            mismatch_q <= 1'b1;
            fail_idx_q <= chk_ptr_q;
          end
          if (chk_last) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            pass_q  <= !(mismatch_q || cmp_miss);
          end else begin
            chk_ptr_q <= chk_ptr_q + CW'(1);
            state_q   <= CHK_REQ;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: each output gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    core_hold = 1'b1;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      LOAD: begin
        mem_we    = 1'b1;
        mem_addr  = img_rd_addr;
        mem_wdata = img_rd_data;
      end
      RUN:     core_hold = 1'b0;
      CHK_REQ: begin
        mem_re   = 1'b1;
        mem_addr = chk_rd_addr;
      end
      default: ;
    endcase
  end

  assign busy     = !idle;
  assign done     = done_q;
  assign pass     = pass_q;
  assign fail_idx = fail_idx_q;

endmodule
